// File: rtl/co_k_rom_arbiter.sv
// co_k_rom_arbiter
// Shares one single-port coefficient-K ROM between NUM_REQ lookup clients.
// A round-robin grant issues at most one ROM read per cycle. A small tracking
// pipe follows each read through the fixed ROM latency and tags the returned
// coefficient with the index of the requester that asked for it.
module co_k_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_dout,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    // Index of the most recently granted requester; the search starts just past it.
    logic [ID_W-1:0]               r_ptr;
    // Tracking pipe: one {vld, id} entry per cycle of ROM latency.
    logic [ROM_LAT-1:0]            r_vld;
    logic [ROM_LAT-1:0][ID_W-1:0]  r_id;

    logic [NUM_REQ-1:0]            w_grant;
    logic                          w_found;
    logic [ID_W-1:0]               w_win_id;
    logic [ADDR_W-1:0]             w_win_addr;

    // Round-robin search: positions ptr+1, ptr+2, ... (mod NUM_REQ); first valid wins.
    // The inner loop turns the rotated position back into a constant bit index.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_win_id   = '0;
        w_win_addr = '0;
        if (arb_en && !rst) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!w_found && (j == ((int'(r_ptr) + i) % NUM_REQ)) && req_valid[j]) begin
                        w_found    = 1'b1;
                        w_grant[j] = 1'b1;
                        w_win_id   = ID_W'(j);
                        w_win_addr = req_addr[j*ADDR_W +: ADDR_W];
                    end
                end
            end
        end
    end

    // Grant and ROM issue outputs; address reads as zero when nothing is granted.
    always_comb begin
        req_ready = w_grant;
        rom_en    = w_found;
        rom_addr  = w_win_addr;
    end

    // Pointer follows the winner; it holds while idle or while arbitration is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_ptr <= w_win_id;
        end
    end

    // Tracking pipe shifts every cycle so responses come back in grant order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld[0] <= w_found;
            r_id[0]  <= w_win_id;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
        end
    end

    // Response is tagged from the last pipe stage; ROM data passes straight through.
    always_comb begin
        rsp_valid = r_vld[ROM_LAT-1];
        rsp_id    = r_id[ROM_LAT-1];
        rsp_data  = rom_dout;
        busy      = |r_vld;
    end

endmodule

// File: tb/tb_co_k_rom_arbiter.sv
// Bench for co_k_rom_arbiter: three configurations (2 req/lat 1, 2 req/lat 2,
// 4 req/lat 1), directed scenarios plus randomized traffic, all checked each
// cycle against a queue-based model of round-robin grants and latency.
module tb_co_k_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nrq(input int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic int lat(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Per-configuration stimulus
    logic        rst_v[3];
    logic        arb_v[3];
    logic [3:0]  rv[3];
    logic [39:0] ra[3];

    // Per-instance DUT outputs
    logic [1:0]  rdy0, rdy1;
    logic [3:0]  rdy2;
    logic        en0, en1, en2, rsv0, rsv1, rsv2, id0, id1, busy0, busy1, busy2;
    logic [1:0]  id2;
    logic [9:0]  ad0, ad1, ad2;
    logic [19:0] dat0, dat1, dat2, dout0, dout1, dout2;

    // Gathered views, indexed by configuration
    logic [3:0]  o_rdy[3];
    logic        o_en[3];
    logic [9:0]  o_addr[3];
    logic        o_rv[3];
    logic [1:0]  o_id[3];
    logic [19:0] o_data[3];
    logic        o_busy[3];

    co_k_rom_arbiter #(.NUM_REQ(2), .ID_W(1), .ROM_LAT(1), .ADDR_W(10), .DATA_W(20)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .arb_en(arb_v[0]), .req_valid(rv[0][1:0]),
        .req_addr(ra[0][19:0]), .req_ready(rdy0), .rom_en(en0), .rom_addr(ad0),
        .rom_dout(dout0), .rsp_valid(rsv0), .rsp_id(id0), .rsp_data(dat0), .busy(busy0));

    co_k_rom_arbiter #(.NUM_REQ(2), .ID_W(1), .ROM_LAT(2), .ADDR_W(10), .DATA_W(20)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .arb_en(arb_v[1]), .req_valid(rv[1][1:0]),
        .req_addr(ra[1][19:0]), .req_ready(rdy1), .rom_en(en1), .rom_addr(ad1),
        .rom_dout(dout1), .rsp_valid(rsv1), .rsp_id(id1), .rsp_data(dat1), .busy(busy1));

    co_k_rom_arbiter #(.NUM_REQ(4), .ID_W(2), .ROM_LAT(1), .ADDR_W(10), .DATA_W(20)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .arb_en(arb_v[2]), .req_valid(rv[2]),
        .req_addr(ra[2]), .req_ready(rdy2), .rom_en(en2), .rom_addr(ad2),
        .rom_dout(dout2), .rsp_valid(rsv2), .rsp_id(id2), .rsp_data(dat2), .busy(busy2));

    always_comb begin
        o_rdy[0] = {2'b00, rdy0}; o_rdy[1] = {2'b00, rdy1}; o_rdy[2] = rdy2;
        o_en[0] = en0; o_en[1] = en1; o_en[2] = en2;
        o_addr[0] = ad0; o_addr[1] = ad1; o_addr[2] = ad2;
        o_rv[0] = rsv0; o_rv[1] = rsv1; o_rv[2] = rsv2;
        o_id[0] = {1'b0, id0}; o_id[1] = {1'b0, id1}; o_id[2] = id2;
        o_data[0] = dat0; o_data[1] = dat1; o_data[2] = dat2;
        o_busy[0] = busy0; o_busy[1] = busy1; o_busy[2] = busy2;
    end

    // ROM models: dout = {10'h0, addr} delayed by the configured latency
    logic [9:0] rom_pipe[3][2];
    always @(posedge clk) begin
        rom_pipe[0][0] <= ad0; rom_pipe[0][1] <= rom_pipe[0][0];
        rom_pipe[1][0] <= ad1; rom_pipe[1][1] <= rom_pipe[1][0];
        rom_pipe[2][0] <= ad2; rom_pipe[2][1] <= rom_pipe[2][0];
    end
    assign dout0 = {10'h0, rom_pipe[0][0]};
    assign dout1 = {10'h0, rom_pipe[1][1]};
    assign dout2 = {10'h0, rom_pipe[2][0]};

    // Behavioural model state
    typedef struct {
        int due;
        int id;
        int addr;
    } rsp_t;
    rsp_t q[$];
    int   m_ptr;
    int   m_gnt;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   g_log[$], g_cyc[$], r_id_log[$], r_dat_log[$], r_cyc[$];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d cyc=%0d actual=0x%0h required=0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        g_log.delete(); g_cyc.delete(); r_id_log.delete(); r_dat_log.delete(); r_cyc.delete();
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model
    task automatic check_cycle(input int k);
        int nr;
        int win;
        logic [9:0] wa;
        bit hit;
        nr = nrq(k);
        if (rst_v[k]) begin
            q.delete();
            m_ptr = nr - 1;
            m_gnt = -1;
            chk("rst_ready", k, o_rdy[k], 0);
            chk("rst_rom_en", k, o_en[k], 0);
            chk("rst_rsp_valid", k, o_rv[k], 0);
            chk("rst_rsp_id", k, o_id[k], 0);
            chk("rst_busy", k, o_busy[k], 0);
        end else begin
            chk("busy", k, o_busy[k], q.size() > 0);
            hit = (q.size() > 0) && (q[0].due == cyc);
            chk("rsp_valid", k, o_rv[k], hit);
            if (o_rv[k]) begin
                r_id_log.push_back(int'(o_id[k]));
                r_dat_log.push_back(int'(o_data[k]));
                r_cyc.push_back(cyc);
            end
            if (hit) begin
                chk("rsp_id", k, o_id[k], q[0].id);
                chk("rsp_data", k, o_data[k], q[0].addr);
                void'(q.pop_front());
            end
            win = -1;
            if (arb_v[k]) begin
                for (int i = 1; i <= nr; i++) begin
                    int idx;
                    idx = (m_ptr + i) % nr;
                    if (win < 0 && rv[k][idx]) win = idx;
                end
            end
            chk("req_ready", k, o_rdy[k], (win < 0) ? 0 : (1 << win));
            chk("rom_en", k, o_en[k], win >= 0);
            wa = (win < 0) ? 10'h0 : ra[k][win*10 +: 10];
            chk("rom_addr", k, o_addr[k], wa);
            for (int j = 0; j < nr; j++) begin
                if (o_rdy[k][j]) begin
                    g_log.push_back(j);
                    g_cyc.push_back(cyc);
                end
            end
            m_gnt = win;
            if (win >= 0) begin
                m_ptr = win;
                q.push_back('{cyc + lat(k), win, int'(wa)});
            end
        end
        cyc++;
    endtask

    task automatic tick_a(input int k);
        @(negedge clk);
        check_cycle(k);
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int k);
        tick_a(k);
        tick_b();
    endtask

    task automatic do_reset(input int k);
        rst_v[k] = 1'b1;
        arb_v[k] = 1'b1;
        rv[k]    = '0;
        step(k);
        step(k);
        rst_v[k] = 1'b0;
    endtask

    // Random traffic honouring the hold-until-granted rule (dropping is allowed)
    task automatic rand_cycle(input int k);
        rst_v[k] = ($urandom_range(0, 99) == 0);
        arb_v[k] = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < nrq(k); i++) begin
            if (rv[k][i] && m_gnt != i) begin
                if ($urandom_range(0, 7) == 0) rv[k][i] = 1'b0;
            end else begin
                rv[k][i] = 1'($urandom_range(0, 1));
                ra[k][i*10 +: 10] = 10'($urandom_range(0, 1023));
            end
        end
        step(k);
    endtask

    initial begin
        int e2g[4] = '{0, 1, 0, 1};
        int e2d[4] = '{16, 32, 16, 32};
        int e3d[3] = '{1023, 0, 341};
        int e6g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; arb_v[k] = 1'b1; rv[k] = '0; ra[k] = '0;
        end
        m_ptr = 0;
        m_gnt = -1;
        tick_b();

        // ---- configuration 0: NUM_REQ=2, ROM_LAT=1 ----
        do_reset(0);
        // T1: single short request
        rv[0] = 4'b0001; ra[0][9:0] = 10'h005;
        tick_a(0);
        chk("t1_ready", 0, o_rdy[0], 1);
        chk("t1_rom_en", 0, o_en[0], 1);
        chk("t1_rom_addr", 0, o_addr[0], 5);
        tick_b();
        rv[0] = '0;
        tick_a(0);
        chk("t1_rsp_valid", 0, o_rv[0], 1);
        chk("t1_rsp_id", 0, o_id[0], 0);
        chk("t1_rsp_data", 0, o_data[0], 5);
        tick_b();
        step(0);

        // T2: both valid for 4 cycles straight after reset
        do_reset(0);
        clear_logs();
        rv[0] = 4'b0011; ra[0][9:0] = 10'h010; ra[0][19:10] = 10'h020;
        repeat (4) step(0);
        rv[0] = '0;
        repeat (2) step(0);
        chk("t2_ngrant", 0, g_log.size(), 4);
        chk("t2_nrsp", 0, r_id_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", 0, g_log[i], e2g[i]);
            chk("t2_rsp_id", 0, r_id_log[i], e2g[i]);
            chk("t2_rsp_data", 0, r_dat_log[i], e2d[i]);
        end
        chk("t2_no_idle", 0, r_cyc[3] - r_cyc[0], 3);

        // T4: drop arb_en after the first grant
        do_reset(0);
        clear_logs();
        rv[0] = 4'b0011;
        step(0);
        arb_v[0] = 1'b0;
        repeat (3) step(0);
        chk("t4_nrsp", 0, r_id_log.size(), 1);
        chk("t4_busy_low", 0, o_busy[0], 0);
        arb_v[0] = 1'b1;
        tick_a(0);
        chk("t4_regrant", 0, o_rdy[0], 2);
        tick_b();
        rv[0] = '0;
        step(0);

        // T5: reset one cycle after a grant
        do_reset(0);
        rv[0] = 4'b0001; ra[0][9:0] = 10'h007;
        step(0);
        rv[0] = '0;
        rst_v[0] = 1'b1;
        tick_a(0);
        chk("t5_rsp_valid", 0, o_rv[0], 0);
        tick_b();
        step(0);
        rst_v[0] = 1'b0;
        rv[0] = 4'b0011;
        tick_a(0);
        chk("t5_first_grant", 0, o_rdy[0], 1);
        tick_b();
        rv[0] = '0;
        step(0);

        repeat (400) rand_cycle(0);
        rst_v[0] = 1'b1;

        // ---- configuration 1: NUM_REQ=2, ROM_LAT=2 ----
        do_reset(1);
        clear_logs();
        rv[1] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            ra[1][19:10] = 10'(e3d[i]);
            step(1);
        end
        rv[1] = '0;
        repeat (3) step(1);
        chk("t3_nrsp", 1, r_id_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_rsp_id", 1, r_id_log[i], 1);
            chk("t3_rsp_data", 1, r_dat_log[i], e3d[i]);
        end
        chk("t3_latency", 1, r_cyc[0] - g_cyc[0], 2);
        chk("t3_back_to_back", 1, r_cyc[2] - r_cyc[0], 2);

        repeat (400) rand_cycle(1);
        rst_v[1] = 1'b1;

        // ---- configuration 2: NUM_REQ=4, ROM_LAT=1 ----
        do_reset(2);
        clear_logs();
        rv[2] = 4'b1111;
        ra[2] = {10'h333, 10'h222, 10'h111, 10'h0AA};
        repeat (8) step(2);
        rv[2] = '0;
        repeat (2) step(2);
        chk("t6_ngrant", 2, g_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t6_grant", 2, g_log[i], e6g[i]);
        for (int i = 0; i < 4; i++) chk("t6_wait", 2, g_cyc[i+4] - g_cyc[i], 4);

        repeat (400) rand_cycle(2);
        rst_v[2] = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
